// File: rtl/queue_req_arbiter.sv
// Two-way round-robin request arbiter with in-order response routing.
// Owner tracking FIFO steers each downstream response back to its requester.
module queue_req_arbiter #(
  parameter int DATA_SIZE   = 32,
  parameter int OUTSTANDING = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           kill,
  input  logic                           a_valid,
  output logic                           a_ready,
  input  logic [DATA_SIZE-1:0]           a_data,
  input  logic                           b_valid,
  output logic                           b_ready,
  input  logic [DATA_SIZE-1:0]           b_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_SIZE-1:0]           out_data,
  input  logic                           resp_valid,
  output logic                           resp_ready,
  input  logic [DATA_SIZE-1:0]           resp_data,
  output logic                           a_resp_valid,
  input  logic                           a_resp_ready,
  output logic                           b_resp_valid,
  input  logic                           b_resp_ready,
  output logic [DATA_SIZE-1:0]           resp_data_out,
  output logic [$clog2(OUTSTANDING):0]   outstanding,
  output logic                           orphan_err
);

  localparam int PW = $clog2(OUTSTANDING);
  localparam int CW = PW + 1;
  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  logic [OUTSTANDING-1:0] id_q;
  logic [OUTSTANDING-1:0] drop_q;
  logic [PW-1:0]          head;
  logic [PW-1:0]          tail;
  logic [CW-1:0]          count;
  logic                   last_grant;
  logic                   lock;
  logic                   locked_id;
  logic                   orphan_q;

  logic grant;
  logic gvalid;
  logic full;
  logic empty;
  logic fwd_ok;
  logic push;
  logic pop;
  logic head_id;
  logic head_drop;

  always_comb begin
    grant = ~last_grant;
    if (lock)
      grant = locked_id;
    else if (a_valid && !b_valid)
      grant = ID_A;
    else if (b_valid && !a_valid)
      grant = ID_B;
  end

  assign full   = (count == CW'(OUTSTANDING));
  assign empty  = (count == '0);
  assign fwd_ok = !full && !kill && !reset;
  assign gvalid = grant ? b_valid : a_valid;

  assign out_valid = gvalid && fwd_ok;
  assign out_data  = grant ? b_data : a_data;
  assign a_ready   = (grant == ID_A) && out_ready && fwd_ok;
  assign b_ready   = (grant == ID_B) && out_ready && fwd_ok;
  assign push      = out_valid && out_ready;

  // A kill this cycle already marks the head as dropped.
  assign head_id   = id_q[head];
  assign head_drop = drop_q[head] || kill;

  always_comb begin
    resp_ready   = 1'b0;
    a_resp_valid = 1'b0;
    b_resp_valid = 1'b0;
    if (!reset) begin
      if (empty || head_drop) begin
        resp_ready = 1'b1;
      end else if (head_id == ID_B) begin
        b_resp_valid = resp_valid;
        resp_ready   = b_resp_ready;
      end else begin
        a_resp_valid = resp_valid;
        resp_ready   = a_resp_ready;
      end
    end
  end

  assign pop           = resp_valid && resp_ready && !empty;
  assign resp_data_out = resp_data;
  assign outstanding   = count;
  assign orphan_err    = orphan_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      id_q       <= '0;
      drop_q     <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      last_grant <= ID_B;
      lock       <= 1'b0;
      locked_id  <= ID_A;
      orphan_q   <= 1'b0;
    end else begin
      if (kill)
        drop_q <= '1;
      if (push) begin
        id_q[tail]   <= grant;
        drop_q[tail] <= 1'b0;
        tail         <= tail + 1'b1;
      end
      if (pop)
        head <= head + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
      if (kill) begin
        lock <= 1'b0;
      end else if (push) begin
        lock       <= 1'b0;
        last_grant <= grant;
      end else if (out_valid && !out_ready) begin
        lock      <= 1'b1;
        locked_id <= grant;
      end
      if (resp_valid && empty)
        orphan_q <= 1'b1;
    end
  end

endmodule
